// File: rtl/lstm_fixed_pkg.sv
// Shared Q3.12 fixed-point constants and types for the LSTM datapath blocks.
package lstm_fixed_pkg;

  localparam int unsigned W     = 16;
  localparam int unsigned FRAC  = 12;
  // Dividend width once the magnitude is pre-shifted by FRAC; also the iteration count.
  localparam int unsigned DW    = W + FRAC;
  localparam int unsigned Iters = DW;
  localparam int unsigned CntW  = 5;

  localparam logic [W-1:0] QMAX = 16'h7FFF;
  localparam logic [W-1:0] QMIN = 16'h8000;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StFin
  } div_state_e;

  // Two's-complement magnitude; 0x8000 maps to 32768 as an unsigned value.
  function automatic logic [W-1:0] abs_mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/signeddiv_seq_if.sv
// Start/done handshake and operand/result bundle for the sequential divider.
interface signeddiv_seq_if;
  import lstm_fixed_pkg::*;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic         ovf;
  logic         dz;

  modport master (
    output start, a, b,
    input  busy, done, q, ovf, dz
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, ovf, dz
  );

endinterface

// File: rtl/signeddiv_seq_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_step
  import lstm_fixed_pkg::*;
(
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W+1:0] trial;
  logic [W:0]   diff;

  // Shift in the next dividend bit, subtract when the divisor fits.
  always_comb begin
    trial = {rem_i, bit_i};
    diff  = trial[W:0] - {1'b0, div_i};
    q_o   = (trial >= {2'b00, div_i});
    rem_o = q_o ? diff : trial[W:0];
  end

endmodule

// File: rtl/signeddiv_seq.sv
// Sequential signed Q3.12 divider: sign-magnitude restoring division, fixed 29-cycle latency.
module signeddiv_seq
  import lstm_fixed_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  signeddiv_seq_if.slave   bus_io
);

  div_state_e state_q, state_d;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   dvd_q, dvd_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [W:0]      rem_q, rem_d;
  logic [W-1:0]    mag_b_q, mag_b_d;
  logic            sign_q, sign_d;
  logic [W-1:0]    qout_q, qout_d;
  logic            ovf_q, ovf_d;
  logic            dz_q, dz_d;
  logic            done_q, done_d;

  logic            load_en, step_en, fin_en, busy;
  logic [W:0]      step_rem;
  logic            step_bit;

  div_step u_div_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[DW-1]),
    .div_i (mag_b_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in idle, so it never queues.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus_io.start) state_d = StDiv;
      StDiv:   if (cnt_q == CntW'(Iters - 1)) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM decoded controls.
  always_comb begin
    load_en = 1'b0;
    step_en = 1'b0;
    fin_en  = 1'b0;
    busy    = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy    = 1'b0;
        load_en = bus_io.start;
      end
      StDiv:   step_en = 1'b1;
      StFin:   fin_en  = 1'b1;
      default: busy    = 1'b0;
    endcase
  end

  // Datapath next state: operand load, iteration, and saturating result formatting.
  always_comb begin
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    mag_b_d = mag_b_q;
    sign_d  = sign_q;
    qout_d  = qout_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    done_d  = fin_en;

    if (load_en) begin
      sign_d  = bus_io.a[W-1] ^ bus_io.b[W-1];
      mag_b_d = abs_mag(bus_io.b);
      dvd_d   = {abs_mag(bus_io.a), {FRAC{1'b0}}};
      rem_d   = '0;
      quo_d   = '0;
      cnt_d   = '0;
    end

    if (step_en) begin
      rem_d = step_rem;
      dvd_d = dvd_q << 1;
      quo_d = {quo_q[DW-2:0], step_bit};
      cnt_d = cnt_q + 1'b1;
    end

    if (fin_en) begin
      // A zero magnitude can only come from b == 0.
      if (mag_b_q == '0) begin
        qout_d = sign_q ? QMIN : QMAX;
        ovf_d  = 1'b0;
        dz_d   = 1'b1;
      end else if (!sign_q && (quo_q > DW'(QMAX))) begin
        qout_d = QMAX;
        ovf_d  = 1'b1;
        dz_d   = 1'b0;
      end else if (sign_q && (quo_q > DW'(QMIN))) begin
        qout_d = QMIN;
        ovf_d  = 1'b1;
        dz_d   = 1'b0;
      end else begin
        // Negating a zero magnitude yields 0x0000, so no negative zero.
        qout_d = sign_q ? (~quo_q[W-1:0] + 1'b1) : quo_q[W-1:0];
        ovf_d  = 1'b0;
        dz_d   = 1'b0;
      end
    end
  end

  // Datapath registers; reset discards any in-flight division.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      mag_b_q <= '0;
      sign_q  <= 1'b0;
      qout_q  <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      mag_b_q <= mag_b_d;
      sign_q  <= sign_d;
      qout_q  <= qout_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign bus_io.busy = busy;
  assign bus_io.done = done_q;
  assign bus_io.q    = qout_q;
  assign bus_io.ovf  = ovf_q;
  assign bus_io.dz   = dz_q;

endmodule

// File: tb/tb_signeddiv_seq.sv
// Self-checking bench for signeddiv_seq: directed table, handshake/reset sequences, random vs model.
module tb_signeddiv_seq;

  logic clk = 1'b0;
  logic reset;

  signeddiv_seq_if bus ();

  signeddiv_seq dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        ovf;
    logic        dz;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact rational a/b scaled by 2^12, truncated toward zero, then saturated.
  function automatic void model(input logic [15:0] ia, input logic [15:0] ib,
                                output logic [15:0] q, output logic ovf, output logic dz);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    if (sb == 0) begin
      dz  = 1'b1;
      ovf = 1'b0;
      q   = (sa < 0) ? 16'h8000 : 16'h7FFF;
    end else begin
      dz = 1'b0;
      r  = (sa * 4096) / sb;
      if (r > 32767) begin
        q   = 16'h7FFF;
        ovf = 1'b1;
      end else if (r < -32768) begin
        q   = 16'h8000;
        ovf = 1'b1;
      end else begin
        q   = r[15:0];
        ovf = 1'b0;
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic launch(input logic [15:0] ia, input logic [15:0] ib);
    bus.a     = ia;
    bus.b     = ib;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts posedges until done is seen; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) break;
    end
  endtask

  task automatic check_res(input string name, input int lat, input logic [15:0] eq,
                           input logic eovf, input logic edz);
    chk({name, "_latency"}, lat, 29);
    chk({name, "_q"}, bus.q, eq);
    chk({name, "_ovf"}, bus.ovf, eovf);
    chk({name, "_dz"}, bus.dz, edz);
    chk({name, "_busy_at_done"}, bus.busy, 1'b0);
  endtask

  task automatic run_check(input string name, input logic [15:0] ia, input logic [15:0] ib,
                           input logic [15:0] eq, input logic eovf, input logic edz);
    int lat;
    launch(ia, ib);
    chk({name, "_busy"}, bus.busy, 1'b1);
    wait_done(lat);
    check_res(name, lat, eq, eovf, edz);
    @(negedge clk);
    chk({name, "_done_pulse"}, bus.done, 1'b0);
    chk({name, "_q_hold"}, bus.q, eq);
  endtask

  initial begin
    int          lat;
    int          ndone;
    logic [15:0] cap_q;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] mq;
    logic        movf;
    logic        mdz;
    int          mode;

    vecs[0] = '{16'h1000, 16'h2000, 16'h0800, 1'b0, 1'b0};
    vecs[1] = '{16'hF000, 16'h0800, 16'hE000, 1'b0, 1'b0};
    vecs[2] = '{16'h1000, 16'h3000, 16'h0555, 1'b0, 1'b0};
    vecs[3] = '{16'hF000, 16'h3000, 16'hFAAB, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h1000, 16'h8000, 1'b0, 1'b0};
    vecs[6] = '{16'h3000, 16'h0000, 16'h7FFF, 1'b0, 1'b1};
    vecs[7] = '{16'hD000, 16'h0000, 16'h8000, 1'b0, 1'b1};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_q", bus.q, 16'h0000);
    chk("reset_ovf", bus.ovf, 1'b0);
    chk("reset_dz", bus.dz, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].ovf, vecs[i].dz);
    end

    // Second start while busy is ignored; exactly one done with the first result.
    launch(16'h1000, 16'h2000);
    repeat (4) @(negedge clk);
    launch(16'h2000, 16'h1000);
    ndone = 0;
    cap_q = '0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        cap_q = bus.q;
      end
    end
    chk("busy_start_done_count", ndone, 1);
    chk("busy_start_q", cap_q, 16'h0800);

    // Back-to-back: new start in the done cycle is accepted.
    launch(16'h1000, 16'h3000);
    wait_done(lat);
    check_res("b2b_first", lat, 16'h0555, 1'b0, 1'b0);
    launch(16'hF000, 16'h3000);
    chk("b2b_busy", bus.busy, 1'b1);
    wait_done(lat);
    check_res("b2b_second", lat, 16'hFAAB, 1'b0, 1'b0);
    @(negedge clk);

    // Reset around iteration 15 discards the division.
    launch(16'h7000, 16'h1000);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy", bus.busy, 1'b0);
    chk("midreset_q", bus.q, 16'h0000);
    chk("midreset_done", bus.done, 1'b0);
    chk("midreset_ovf", bus.ovf, 1'b0);
    chk("midreset_dz", bus.dz, 1'b0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midreset_no_done", ndone, 0);
    run_check("after_reset", 16'h7000, 16'h1000, 16'h7000, 1'b0, 1'b0);

    // Randomized against the reference model, biased toward corner operands.
    for (int i = 0; i < 150; i++) begin
      mode = int'($urandom_range(0, 9));
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      if (mode == 0) rb = 16'h0000;
      else if (mode <= 3) rb = 16'($urandom_range(0, 15));
      else if (mode == 4) ra = 16'h8000;
      else if (mode == 5) rb = 16'h8000;
      else if (mode == 6) ra = 16'h0000;
      model(ra, rb, mq, movf, mdz);
      run_check($sformatf("rand%0d_a%h_b%h", i, ra, rb), ra, rb, mq, movf, mdz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signeddiv_seq.md
# signeddiv_seq

Sequential signed fixed-point divider for the LSTM datapath: computes a/b on 16-bit two's-complement Q3.12 operands and returns a Q3.12 quotient. It uses the same sign-magnitude approach and number format as the signed multiplier, so it serves as the inverse operation for normalisation and gate-scaling stages. A radix-2 restoring divider runs one bit per cycle with a fixed latency. A start/done handshake lets a controller issue one division at a time.

## Interface
- W, 16: operand/result width (two's complement)
- FRAC, 12: fractional bits of the operand and result format
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  16  dividend, Q3.12 signed
- b  input  16  divisor, Q3.12 signed
- busy  output  1  high while a division is in flight
- done  output  1  one-cycle pulse; q, ovf and dz are valid that cycle and held afterwards
- q  output  16  quotient, Q3.12 signed, truncated toward zero, saturated
- ovf  output  1  quotient saturated because of magnitude overflow
- dz  output  1  divisor was zero

## Operation
- States: IDLE, DIV, FIN.
- **IDLE**
  - On start=1, latch the sign s = a[15]^b[15].
  - Latch |a| and |b| as 16-bit unsigned values; 0x8000 gives magnitude 32768.
  - Load dividend D = |a| << FRAC (28 bits), clear the partial remainder and the iteration counter, then go to DIV.
- **DIV**, 28 iterations (W+FRAC), one per cycle, MSB first:
  - Shift the remainder left by one and bring in the next D bit.
  - If the remainder is >= |b|, subtract |b| and shift quotient bit 1 in; otherwise shift in 0.
  - Remainder is 17 bits wide to avoid overflow.
  - After the 28th iteration, go to FIN.
- **FIN**, using the 28-bit unsigned quotient Q:
  - If b==0: q = s ? 0x8000 : 0x7FFF, dz=1, ovf=0.
  - Else if s=0 and Q>0x7FFF: q=0x7FFF, ovf=1.
  - Else if s=1 and Q>0x8000: q=0x8000, ovf=1.
  - Else q = s ? (~Q[15:0]+1) : Q[15:0], with ovf=0 and dz=0.
  - Pulse done, then return to IDLE.
- A zero divisor still runs all 28 iterations, so latency is fixed.
- A zero quotient is always 0x0000; negative zero never appears.
- start while busy=1 is ignored and does not queue.
- reset in any state: go to IDLE and clear busy, done, q, ovf, dz and all internal registers on the same edge. An in-flight result is discarded.

## Timing
- Reset values: busy=0, done=0, q=0x0000, ovf=0, dz=0.
- Cycle-level sequence for start sampled high at edge k:
  - busy goes to 1 after edge k and stays 1 through edge k+28.
  - Iterations run on edges k+1 through k+28.
  - q, ovf and dz register on edge k+29; done=1 and busy=0 for the cycle after edge k+29.
- Latency: 29 cycles from start to done.
- Throughput: one division per 30 cycles. start may be asserted in the same cycle as done, since busy=0 then, and is accepted.
- q, ovf and dz hold until the next FIN or reset; they do not change at start.

## Structure
- Shared package `lstm_fixed_pkg`:
  - constants W=16 and FRAC=12;
  - saturation constants QMAX=16'h7FFF and QMIN=16'h8000;
  - state enum {IDLE, DIV, FIN}.
- The multiplier and activation blocks reuse the same package constants.
- One natural sub-module, `div_step`: a combinational single restoring step taking remainder, next dividend bit and divisor, and returning the new remainder and quotient bit. The top level holds the FSM, counter, sign/magnitude conversion and saturation.

## Test plan
- Basic and negative results:
  - a=0x1000, b=0x2000 (1.0/2.0) → done at start+29, q=0x0800, ovf=0, dz=0.
  - a=0xF000, b=0x0800 (-1.0/0.5) → q=0xE000.
- Truncation toward zero:
  - a=0x1000, b=0x3000 → q=0x0555.
  - a=0xF000, b=0x3000 → q=0xFAAB.
- Saturation:
  - a=0x7FFF, b=0x0001 → q=0x7FFF, ovf=1.
  - a=0x8000, b=0x1000 → q=0x8000, ovf=0.
- Divide by zero:
  - a=0x3000, b=0 → q=0x7FFF, dz=1.
  - a=0xD000, b=0 → q=0x8000, dz=1, with latency still 29 cycles.
- Handshake:
  - start pulsed at cycles 5 and 10 with different operands → only the first is computed, and a single done appears.
  - Back-to-back start in the done cycle is accepted.
- Reset:
  - Assert reset at iteration 15 → next cycle busy=0, q=0, no done pulse.
  - A new start afterwards produces the correct result.
